// File: rtl/fpga_top_if.sv
// fpga_top_if -- pin bundle of the audio effect board.
// Groups the ADC serial link, the Pi serial link, the effect switches and the
// LEDs so the top level and its bench share one set of names.
//   dinAdc          ADC DOUT into the FPGA
//   switch[3:0]     [1:0] effect, [2] hold, [3] mute
//   sclkAdc/doutAdc/ncsAdc   ADC serial clock, command bits, chip select (low)
//   sclkPi/doutPi/ncsPi      Pi link serial clock, data, chip select (low)
//   led[7:0]        processed sample bits [9:2]
// Modports: master = FPGA side (drives both serial links), slave = board side.
interface fpga_top_if;
   logic       dinAdc;
   logic [3:0] switch;
   logic       sclkAdc;
   logic       doutAdc;
   logic       ncsAdc;
   logic       sclkPi;
   logic       doutPi;
   logic       ncsPi;
   logic [7:0] led;

   modport master (
      input  dinAdc, switch,
      output sclkAdc, doutAdc, ncsAdc, sclkPi, doutPi, ncsPi, led
   );

   modport slave (
      output dinAdc, switch,
      input  sclkAdc, doutAdc, ncsAdc, sclkPi, doutPi, ncsPi, led
   );
endinterface

// File: rtl/fpga_top.sv
// fpga_top -- reads 10-bit samples from a serial ADC, applies a switch-selected
// effect and streams each processed sample to a Pi over a second serial link.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high
//   io     fpga_top_if.master: ADC link, Pi link, switches, LEDs
// One ADC frame is 288 clk (18 sclk periods of 16 clk); ncsAdc is low for the
// first 256 clk. The sample is complete after period 15, y is registered on the
// next clk and a 256-clk Pi frame starts one clk later, so it always finishes
// before the following update.
module fpga_top (
   input  logic       clk,
   input  logic       reset,
   fpga_top_if.master io
);

   localparam logic [3:0] ADC_CMD    = 4'b1101;
   localparam logic [8:0] FRAME_LAST = 9'd287;
   localparam logic [8:0] Y_UPDATE   = 9'd248;
   localparam logic [8:0] PI_LAUNCH  = 9'd249;

   typedef enum logic {PI_IDLE, PI_SEND} pi_state_t;

   logic       running_q, running_d;
   logic [8:0] frame_cnt_q, frame_cnt_d;
   logic [9:0] shift_q, shift_d;
   logic [9:0] y_q, y_d;
   pi_state_t  pi_state_q, pi_state_d;
   logic [7:0] pi_cnt_q, pi_cnt_d;
   logic [15:0] pi_word_q, pi_word_d;

   logic [4:0] period;
   logic [3:0] phase;
   logic       adc_window;
   logic       sample_now;
   logic       update_now;
   logic       pi_start;
   logic       pi_active;
   logic [9:0] effect_y;

   // Frame position decode. running_q stays low during reset so the first
   // frame begins with the first clk after release, not during reset.
   assign period     = frame_cnt_q[8:4];
   assign phase      = frame_cnt_q[3:0];
   assign adc_window = running_q && !frame_cnt_q[8];
   assign sample_now = adc_window && (phase == 4'd7) && (period >= 5'd6);
   assign update_now = running_q && (frame_cnt_q == Y_UPDATE);
   assign pi_start   = running_q && (frame_cnt_q == PI_LAUNCH);
   assign pi_active  = (pi_state_q == PI_SEND);

   // Effect applied to the assembled sample; mute and hold are handled when
   // y is updated so that mute wins over hold.
   always_comb begin
      effect_y = shift_q;
      case (io.switch[1:0])
         2'b00:   effect_y = shift_q;
         2'b01:   effect_y = 10'd1023 - shift_q;
         2'b10:   effect_y = {1'b0, shift_q[9:1]} + 10'd256;
         default: effect_y = shift_q & 10'h3C0;
      endcase
   end

   // Next-state for the ADC side: free-running frame counter, the sample
   // shifter (clocked in on the edge that raises sclkAdc) and the y register,
   // which is the only place the switches are looked at.
   always_comb begin
      running_d   = 1'b1;
      frame_cnt_d = frame_cnt_q;
      shift_d     = shift_q;
      y_d         = y_q;
      if (running_q) begin
         frame_cnt_d = (frame_cnt_q == FRAME_LAST) ? 9'd0 : frame_cnt_q + 9'd1;
      end
      if (sample_now) begin
         shift_d = {shift_q[8:0], io.dinAdc};
      end
      if (update_now) begin
         if (io.switch[3]) begin
            y_d = 10'd512;
         end else if (!io.switch[2]) begin
            y_d = effect_y;
         end
      end
   end

   // Pi transmitter: idles until launched by the frame counter, latches the
   // word so later y changes cannot corrupt a frame in flight, then counts
   // out 16 bit periods of 16 clk each.
   always_comb begin
      pi_state_d = pi_state_q;
      pi_cnt_d   = pi_cnt_q;
      pi_word_d  = pi_word_q;
      case (pi_state_q)
         PI_IDLE: begin
            if (pi_start) begin
               pi_state_d = PI_SEND;
               pi_cnt_d   = 8'd0;
               pi_word_d  = {6'b0, y_q};
            end
         end
         PI_SEND: begin
            pi_cnt_d = pi_cnt_q + 8'd1;
            if (pi_cnt_q == 8'd255) begin
               pi_state_d = PI_IDLE;
               pi_word_d  = 16'd0;
            end
         end
         default: pi_state_d = PI_IDLE;
      endcase
   end

   // State registers; reset clears everything, which also aborts any frame
   // in progress and throws away a partially shifted sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         running_q   <= 1'b0;
         frame_cnt_q <= 9'd0;
         shift_q     <= 10'd0;
         y_q         <= 10'd0;
         pi_state_q  <= PI_IDLE;
         pi_cnt_q    <= 8'd0;
         pi_word_q   <= 16'd0;
      end else begin
         running_q   <= running_d;
         frame_cnt_q <= frame_cnt_d;
         shift_q     <= shift_d;
         y_q         <= y_d;
         pi_state_q  <= pi_state_d;
         pi_cnt_q    <= pi_cnt_d;
         pi_word_q   <= pi_word_d;
      end
   end

   // Serial outputs are decoded from the counters. Data bits change at the
   // start of a period, while the serial clock is still low.
   assign io.ncsAdc  = !adc_window;
   assign io.sclkAdc = adc_window && phase[3];
   assign io.doutAdc = adc_window && (period < 5'd4) && ADC_CMD[2'd3 - period[1:0]];
   assign io.ncsPi   = !pi_active;
   assign io.sclkPi  = pi_active && pi_cnt_q[3];
   assign io.doutPi  = pi_active && pi_word_q[4'd15 - pi_cnt_q[7:4]];
   assign io.led     = y_q[9:2];

endmodule

// File: tb/tb_fpga_top.sv
// tb_fpga_top -- self-checking bench for fpga_top.
// Plays the ADC (shifting sample bits out in periods 6-15, noise elsewhere),
// receives the Pi link, and compares every cycle against a frame-level model
// of the expected pin behaviour, y value and transmitted words.
module tb_fpga_top;

   logic clk;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   fpga_top_if io ();

   fpga_top dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   // Free-running 10-unit clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [9:0]  yModel;
   int          piLeft;
   bit          piArm;
   logic [15:0] piExpQ[$];
   logic [15:0] piShift;
   int          piBits;
   logic        prevSclkPi;
   logic        prevNcsPi;
   logic        prevSclkAdc;
   int          adcRises;
   logic [3:0]  adcCmd;

   // Single comparison point: counts the check and reports any difference
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Effect rules written as plain arithmetic on the sample value
   function automatic logic [9:0] effectModel(input logic [9:0] x, input logic [3:0] sw,
                                              input logic [9:0] prev);
      int xi;
      xi = int'(x);
      if (sw[3]) return 10'd512;
      if (sw[2]) return prev;
      case (sw[1:0])
         2'd0:    return 10'(xi);
         2'd1:    return 10'(1023 - xi);
         2'd2:    return 10'(xi / 2 + 256);
         default: return 10'((xi / 64) * 64);
      endcase
   endfunction

   // Advance one clk and sample away from the edge; also acts as the Pi
   // receiver and counts ADC serial clock rising edges
   task automatic tick();
      logic [15:0] want;
      @(posedge clk);
      #1;
      if (!io.ncsAdc && !prevSclkAdc && io.sclkAdc) adcRises++;
      if (!io.ncsPi && !prevSclkPi && io.sclkPi) begin
         piShift = {piShift[14:0], io.doutPi};
         piBits++;
      end
      if (!prevNcsPi && io.ncsPi) begin
         checkOutput("pi_bits", piBits, 16);
         checkOutput("pi_pending", piExpQ.size(), 1);
         if (piExpQ.size() > 0) begin
            want = piExpQ.pop_front();
            checkOutput("pi_word", piShift, want);
         end
         piBits  = 0;
         piShift = 16'd0;
      end
      prevSclkAdc = io.sclkAdc;
      prevSclkPi  = io.sclkPi;
      prevNcsPi   = io.ncsPi;
   endtask

   // Pin-level expectations for frame position c
   task automatic checkCycle(input int c);
      int piPos;
      if (piArm) begin
         piLeft = 256;
         piArm  = 1'b0;
      end
      piPos = 256 - piLeft;
      checkOutput("ncsAdc", io.ncsAdc, c >= 256);
      checkOutput("sclkAdc", io.sclkAdc, (c < 256) && ((c % 16) >= 8));
      checkOutput("doutAdc", io.doutAdc, (c < 64) ? adcCmd[3 - c / 16] : 1'b0);
      checkOutput("ncsPi", io.ncsPi, piLeft == 0);
      checkOutput("sclkPi", io.sclkPi, (piLeft > 0) && ((piPos % 16) >= 8));
      if (piLeft == 0) checkOutput("doutPi_idle", io.doutPi, 1'b0);
      checkOutput("led", io.led, yModel[9:2]);
      if (piLeft > 0) piLeft--;
   endtask

   // One ADC frame (or its first stopAt cycles) delivering sample x with
   // switch setting sw; the switch is scrambled after the update point
   task automatic applyStimulus(input logic [9:0] x, input logic [3:0] sw,
                                input bit noise, input int stopAt);
      for (int c = 0; c < stopAt; c++) begin
         int p;
         p = c / 16;
         if (c == 0) begin
            io.switch = sw;
            adcRises  = 0;
         end
         if (c == 250) io.switch = 4'($urandom_range(0, 15));
         if (p >= 6 && p <= 15) io.dinAdc = x[15 - p];
         else io.dinAdc = noise ? 1'($urandom_range(0, 1)) : x[9];
         tick();
         if (c == 249) begin
            yModel = effectModel(x, sw, yModel);
            piExpQ.push_back({6'b0, yModel});
         end
         checkCycle(c);
         if (c == 249) piArm = 1'b1;
         if (c == 287) checkOutput("adc_sclk_rises", adcRises, 16);
      end
   endtask

   task automatic checkReset();
      checkOutput("rst_ncsAdc", io.ncsAdc, 1'b1);
      checkOutput("rst_ncsPi", io.ncsPi, 1'b1);
      checkOutput("rst_sclkAdc", io.sclkAdc, 1'b0);
      checkOutput("rst_sclkPi", io.sclkPi, 1'b0);
      checkOutput("rst_doutAdc", io.doutAdc, 1'b0);
      checkOutput("rst_doutPi", io.doutPi, 1'b0);
      checkOutput("rst_led", io.led, 8'h00);
   endtask

   // Assert reset now, hold it for a few clocks, release on a falling edge
   task automatic applyReset(input int cycles);
      reset = 1'b1;
      #1;
      checkReset();
      yModel      = 10'd0;
      piLeft      = 0;
      piArm       = 1'b0;
      piExpQ.delete();
      piBits      = 0;
      piShift     = 16'd0;
      prevNcsPi   = 1'b1;
      prevSclkPi  = 1'b0;
      prevSclkAdc = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         @(posedge clk);
         #1;
         checkReset();
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Directed requirement cases, random frames, hold/mute and mid-frame reset
   initial begin
      adcCmd    = 4'b1101;
      io.dinAdc = 1'b0;
      io.switch = 4'b0000;
      reset     = 1'b1;
      applyReset(4);

      applyStimulus(10'h3FF, 4'b0000, 1'b0, 288);
      checkOutput("req027_led", io.led, 8'hFF);
      applyStimulus(10'h3FF, 4'b0001, 1'b0, 288);
      checkOutput("req028_led", io.led, 8'h00);
      applyStimulus(10'h000, 4'b0010, 1'b0, 288);
      checkOutput("req029_led_shift", io.led, 8'h40);
      applyStimulus(10'h000, 4'b1010, 1'b0, 288);
      checkOutput("req029_led_mute", io.led, 8'h80);
      applyStimulus(10'h2CE, 4'b0011, 1'b1, 288);
      checkOutput("req030_led", io.led, 8'hB0);

      applyStimulus(10'h123, 4'b0000, 1'b1, 288);
      applyStimulus(10'h3AB, 4'b0100, 1'b1, 288);
      checkOutput("hold_led", io.led, 8'h48);
      applyStimulus(10'h111, 4'b1100, 1'b1, 288);
      checkOutput("mute_over_hold_led", io.led, 8'h80);

      for (int k = 0; k < 6; k++) begin
         applyStimulus(10'($urandom_range(0, 1023)), 4'($urandom_range(0, 15)), 1'b1, 288);
      end

      applyStimulus(10'h3FF, 4'b0000, 1'b1, 101);
      applyReset(3);
      applyStimulus(10'h0A5, 4'b0000, 1'b1, 288);
      checkOutput("post_reset_led", io.led, 8'h29);
      applyStimulus(10'h2F0, 4'b0001, 1'b1, 288);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
